bcd_timekeeper: RTL and testbench
=================================

Name: bcd_timekeeper

Overview:
- Parametrised time-of-day core for the wall-clock display path: keeps HH:MM:SS in packed BCD, generates its own one-second tick and accepts manual set pulses.
- Adds a runtime 12/24-hour display mode, a hold/set mode and a pending-request mechanism for button/tick collisions.
- Sits between the button debouncers and the seven-segment/PWM driver; its BCD outputs feed the display digits directly.

Parameters:
- CLK_DIV, 100000000, clock cycles per second; legal range 2 to 2^32-1.
- DIV_W, $clog2(CLK_DIV), prescaler width.
- RESET_HOURS, 8'h00, 24-hour packed-BCD hours loaded at reset; must be 00-23.
- RESET_MINS, 8'h00, packed-BCD minutes loaded at reset; must be 00-59.

Ports:
- clock  in  1  system clock
- Reset  in  1  synchronous, active-high reset; clock is clock
- inc_min  in  1  single-cycle debounced pulse: minutes +1
- inc_hour  in  1  single-cycle debounced pulse: hours +1
- mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display
- set_hold  in  1  1 = time frozen for setting
- hours_bcd  out  8  displayed hours, packed BCD
- mins_bcd  out  8  minutes, packed BCD
- secs_bcd  out  8  seconds, packed BCD
- pm  out  1  1 when internal hours are 12-23, in either mode
- sec_tick  out  1  one-cycle pulse on every seconds advance

Behaviour:
- Reset, taking priority over everything:
  - prescaler = 0; secs = 00; mins = RESET_MINS; internal hours (24h) = RESET_HOURS.
  - sec_tick = 0; pending flags cleared.
- Prescaler:
  - Counts 0 to CLK_DIV-1 and wraps.
  - sec_tick is registered: it goes high the cycle after the prescaler is at CLK_DIV-1, and the seconds update in that same cycle.
  - First tick after reset release therefore appears CLK_DIV cycles later.
- Seconds carry chain:
  - Seconds 59 wraps to 00 and produces a minute carry.
  - Minutes 59 wraps to 00 on a carry and produces an hour carry.
  - Hours 23 wraps to 00.
  - Each BCD nibble wraps at 9 into the tens nibble; no nibble ever holds a value above 9.
- Buttons:
  - inc_min advances minutes mod 60 with no hour carry.
  - inc_hour advances hours mod 24.
  - Effect is visible on the cycle after the pulse.
- Collision:
  - If inc_min arrives in a cycle where the tick is also advancing minutes, the request is latched in a one-deep pending flag and applied one cycle later.
  - The same rule applies to inc_hour against an hour carry.
  - A second pulse arriving while a flag is already pending is dropped.
- set_hold = 1:
  - Prescaler held at 0, secs forced to 00, sec_tick held at 0.
  - Buttons remain active.
  - On release, counting restarts from prescaler 0, so the next tick comes CLK_DIV cycles later.
- Display mapping, combinational from the internal hours register, adding no latency:
  - mode_12h = 0: hours_bcd equals the internal hours.
  - mode_12h = 1: 00 shows as 12, 01-12 unchanged, 13-23 show as hour minus 12.
  - Changing mode never alters the stored time.
- Reset mid-count discards the partial prescaler count and any pending flags.

Optional Feature:
- Macro: BCD_TIMEKEEPER_ALARM_EN.
- Defined, adds:
  - Inputs alarm_hh[7:0] (24-hour BCD), alarm_mm[7:0], alarm_arm, alarm_ack.
  - Output alarm_flag.
- alarm_flag behaviour:
  - Set on the tick that makes the time alarm_hh:alarm_mm:00 while alarm_arm = 1.
  - Setting the time by button to a matching value does not set it.
  - Stays high until alarm_ack, alarm_arm = 0, or Reset; ack has priority over a simultaneous set.
- Undefined: none of these ports exist and no alarm logic is synthesised.

Test Plan:
- CLK_DIV=4, release Reset -> sec_tick pulses every 4 cycles; first pulse 4 cycles after release; secs goes 00, 01, 02.
- Preload 23:59:58, run 2 ticks -> 23:59:59 then 00:00:00; pm goes 1 to 0.
- mode_12h=1 at hours 00, 12 and 13 -> hours_bcd 12, 12, 01 with pm 0, 1, 1; set mode_12h=0 -> 00, 12, 13.
- At 10:59:59, pulse inc_min on the tick cycle -> 11:00:00 that cycle, then 11:01:00 one cycle later; hours unaffected by the button.
- set_hold=1 at 05:07:33 -> secs reads 00, no sec_tick; 3 inc_hour pulses give 08; release -> first tick CLK_DIV cycles later.
- ALARM_EN, armed for 06:30 -> flag set on the tick into 06:30:00; inc_min from 06:29 to 06:30 does not set it; alarm_ack clears it.

Source files
------------

// File: rtl/bcd_timekeeper.sv
// bcd_timekeeper: HH:MM:SS packed-BCD time-of-day core with own 1 s tick.
// Ports: clock, Reset (sync, active-high); inc_min/inc_hour set pulses;
//   mode_12h display mode; set_hold freezes seconds for setting;
//   hours_bcd/mins_bcd/secs_bcd BCD time; pm (internal hours 12-23);
//   sec_tick one-cycle pulse per seconds advance.
// Optional alarm (macro BCD_TIMEKEEPER_ALARM_EN): alarm_hh, alarm_mm,
//   alarm_arm, alarm_ack inputs and alarm_flag output.
module bcd_timekeeper #(
    parameter int unsigned CLK_DIV     = 100000000,
    parameter int unsigned DIV_W       = $clog2(CLK_DIV),
    parameter logic [7:0]  RESET_HOURS = 8'h00,
    parameter logic [7:0]  RESET_MINS  = 8'h00
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic       inc_min,
    input  logic       inc_hour,
    input  logic       mode_12h,
    input  logic       set_hold,
`ifdef BCD_TIMEKEEPER_ALARM_EN
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    input  logic       alarm_arm,
    input  logic       alarm_ack,
    output logic       alarm_flag,
`endif
    output logic [7:0] hours_bcd,
    output logic [7:0] mins_bcd,
    output logic [7:0] secs_bcd,
    output logic       pm,
    output logic       sec_tick
);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] presc_q, presc_d;
    logic [7:0]       secs_q, secs_d;
    logic [7:0]       mins_q, mins_d;
    logic [7:0]       hours_q, hours_d;
    logic             tick_q;
    logic             pend_min_q, pend_min_d;
    logic             pend_hr_q, pend_hr_d;

    logic             tick_now, min_carry, hr_carry;
    logic             min_btn, hr_btn;
    logic [4:0]       hbin, h12;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] top);
        logic [7:0] r;
        if (v == top)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    always_comb begin
        tick_now  = !set_hold && (presc_q == DIV_MAX);
        min_carry = tick_now && (secs_q == 8'h59);
        hr_carry  = min_carry && (mins_q == 8'h59);

        // A pulse colliding with a carry is deferred one cycle; a pending
        // request is consumed next cycle and any new pulse then is dropped.
        min_btn    = pend_min_q || (inc_min && !min_carry);
        hr_btn     = pend_hr_q || (inc_hour && !hr_carry);
        pend_min_d = inc_min && min_carry && !pend_min_q;
        pend_hr_d  = inc_hour && hr_carry && !pend_hr_q;

        presc_d = (set_hold || tick_now) ? '0 : presc_q + 1'b1;
        secs_d  = set_hold ? 8'h00 :
                  tick_now ? bcd_inc(secs_q, 8'h59) : secs_q;
        mins_d  = (min_carry || min_btn) ? bcd_inc(mins_q, 8'h59) : mins_q;
        hours_d = (hr_carry || hr_btn) ? bcd_inc(hours_q, 8'h23) : hours_q;
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            presc_q    <= '0;
            secs_q     <= 8'h00;
            mins_q     <= RESET_MINS;
            hours_q    <= RESET_HOURS;
            tick_q     <= 1'b0;
            pend_min_q <= 1'b0;
            pend_hr_q  <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            secs_q     <= secs_d;
            mins_q     <= mins_d;
            hours_q    <= hours_d;
            tick_q     <= tick_now;
            pend_min_q <= pend_min_d;
            pend_hr_q  <= pend_hr_d;
        end
    end

    // 12-hour view: 00 -> 12, 13..23 -> 01..11, everything else as stored.
    always_comb begin
        hbin = 5'(hours_q[7:4]) * 5'd10 + 5'(hours_q[3:0]);
        h12  = hbin - 5'd12;
        pm   = (hbin >= 5'd12);
        hours_bcd = hours_q;
        if (mode_12h) begin
            if (hbin == 5'd0)
                hours_bcd = 8'h12;
            else if (hbin > 5'd12)
                hours_bcd = (h12 >= 5'd10) ?
                            {4'd1, 4'(h12 - 5'd10)} : {4'd0, h12[3:0]};
        end
    end

    assign mins_bcd = mins_q;
    assign secs_bcd = secs_q;
    assign sec_tick = tick_q;

`ifdef BCD_TIMEKEEPER_ALARM_EN
    logic alarm_q, alarm_hit;

    // Only a tick rolling into HH:MM:00 may raise the flag.
    assign alarm_hit = min_carry && alarm_arm &&
                       (hours_d == alarm_hh) && (mins_d == alarm_mm);

    always_ff @(posedge clock) begin
        if (Reset)
            alarm_q <= 1'b0;
        else if (alarm_ack || !alarm_arm)
            alarm_q <= 1'b0;
        else if (alarm_hit)
            alarm_q <= 1'b1;
    end

    assign alarm_flag = alarm_q;
`endif

endmodule

// File: tb/tb_bcd_timekeeper.sv
// tb_bcd_timekeeper: checks bcd_timekeeper against an integer time model.
// Directed scenarios plus randomized button/mode/hold/reset traffic.
module tb_bcd_timekeeper;

    localparam int DIV = 4;

    logic       clock = 1'b0;
    logic       Reset = 1'b1;
    logic       inc_min = 1'b0;
    logic       inc_hour = 1'b0;
    logic       mode_12h = 1'b0;
    logic       set_hold = 1'b0;
    logic [7:0] hours_bcd, mins_bcd, secs_bcd;
    logic       pm, sec_tick;
`ifdef BCD_TIMEKEEPER_ALARM_EN
    logic [7:0] alarm_hh = 8'h06;
    logic [7:0] alarm_mm = 8'h30;
    logic       alarm_arm = 1'b0;
    logic       alarm_ack = 1'b0;
    logic       alarm_flag;
`endif

    bcd_timekeeper #(
        .CLK_DIV    (DIV),
        .RESET_HOURS(8'h23),
        .RESET_MINS (8'h59)
    ) dut (
        .clock    (clock),
        .Reset    (Reset),
        .inc_min  (inc_min),
        .inc_hour (inc_hour),
        .mode_12h (mode_12h),
        .set_hold (set_hold),
`ifdef BCD_TIMEKEEPER_ALARM_EN
        .alarm_hh  (alarm_hh),
        .alarm_mm  (alarm_mm),
        .alarm_arm (alarm_arm),
        .alarm_ack (alarm_ack),
        .alarm_flag(alarm_flag),
`endif
        .hours_bcd(hours_bcd),
        .mins_bcd (mins_bcd),
        .secs_bcd (secs_bcd),
        .pm       (pm),
        .sec_tick (sec_tick)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Model state in plain integers.
    int m_cnt, m_s, m_m, m_h;
    bit m_tick, m_pmin, m_phr, m_alarm;

    function automatic int to_bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    function automatic int from_bcd(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    task automatic model_clk();
        bit fire, mc, hc, amin, ahr;
        if (Reset) begin
            m_cnt = 0; m_s = 0; m_m = 59; m_h = 23;
            m_tick = 0; m_pmin = 0; m_phr = 0; m_alarm = 0;
        end else begin
            fire = !set_hold && (m_cnt == DIV - 1);
            mc   = fire && (m_s == 59);
            hc   = mc && (m_m == 59);
            amin = m_pmin || (inc_min && !mc);
            ahr  = m_phr || (inc_hour && !hc);
            m_pmin = inc_min && mc && !m_pmin;
            m_phr  = inc_hour && hc && !m_phr;
            m_s = set_hold ? 0 : (fire ? (m_s + 1) % 60 : m_s);
            m_m = (m_m + int'(mc) + int'(amin)) % 60;
            m_h = (m_h + int'(hc) + int'(ahr)) % 24;
            m_cnt = set_hold ? 0 : (m_cnt + 1) % DIV;
            m_tick = fire;
`ifdef BCD_TIMEKEEPER_ALARM_EN
            if (alarm_ack || !alarm_arm)
                m_alarm = 0;
            else if (mc && m_h == from_bcd(alarm_hh) &&
                     m_m == from_bcd(alarm_mm))
                m_alarm = 1;
`endif
        end
    endtask

    task automatic compare();
        int dh;
        dh = m_h;
        if (mode_12h)
            dh = (m_h % 12 == 0) ? 12 : m_h % 12;
        chk("hours", int'(hours_bcd), to_bcd(dh));
        chk("mins", int'(mins_bcd), to_bcd(m_m));
        chk("secs", int'(secs_bcd), to_bcd(m_s));
        chk("pm", int'(pm), int'(m_h >= 12));
        chk("tick", int'(sec_tick), int'(m_tick));
`ifdef BCD_TIMEKEEPER_ALARM_EN
        chk("alarm", int'(alarm_flag), int'(m_alarm));
`endif
    endtask

    task automatic step();
        @(posedge clock);
        model_clk();
        @(negedge clock);
        compare();
    endtask

    task automatic pulse_hour();
        inc_hour = 1'b1;
        step();
        inc_hour = 1'b0;
        step();
    endtask

    task automatic pulse_min();
        inc_min = 1'b1;
        step();
        inc_min = 1'b0;
        step();
    endtask

    task automatic run_until_tick(input string nm, input int secs_want);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(m_tick && m_s == secs_want) && n < 400);
        chk({nm, "_budget"}, int'(n < 400), 1);
    endtask

    initial begin
        int n;
        step();
        step();
        chk("rst_hours", int'(hours_bcd), 8'h23);
        chk("rst_mins", int'(mins_bcd), 8'h59);
        chk("rst_secs", int'(secs_bcd), 0);
        chk("rst_tick", int'(sec_tick), 0);
        chk("rst_pm", int'(pm), 1);

        Reset = 1'b0;
        step(); step(); step();
        chk("tick_early", int'(sec_tick), 0);
        step();
        chk("first_tick", int'(sec_tick), 1);
        chk("first_secs", int'(secs_bcd), 8'h01);
        step();
        chk("tick_width", int'(sec_tick), 0);

        run_until_tick("to59", 59);
        chk("t235959_h", int'(hours_bcd), 8'h23);
        chk("t235959_s", int'(secs_bcd), 8'h59);
        run_until_tick("wrap", 0);
        chk("wrap_h", int'(hours_bcd), 8'h00);
        chk("wrap_m", int'(mins_bcd), 8'h00);
        chk("wrap_pm", int'(pm), 0);

        chk("m24_00", int'(hours_bcd), 8'h00);
        mode_12h = 1'b1;
        #1 chk("m12_00", int'(hours_bcd), 8'h12);
        repeat (12) pulse_hour();
        chk("m12_12", int'(hours_bcd), 8'h12);
        chk("pm_12", int'(pm), 1);
        pulse_hour();
        chk("m12_13", int'(hours_bcd), 8'h01);
        chk("pm_13", int'(pm), 1);
        mode_12h = 1'b0;
        #1 chk("m24_13", int'(hours_bcd), 8'h13);

        // Collision: inc_min on the tick that carries 10:59:59 -> 11:00:00.
        set_hold = 1'b1;
        step();
        n = 0;
        while (m_h != 10 && n < 30) begin pulse_hour(); n++; end
        n = 0;
        while (m_m != 59 && n < 70) begin pulse_min(); n++; end
        set_hold = 1'b0;
        n = 0;
        do begin step(); n++; end
        while (!(m_s == 59 && m_cnt == DIV - 1) && n < 400);
        chk("coll_budget", int'(n < 400), 1);
        chk("pre_h", int'(hours_bcd), 8'h10);
        chk("pre_m", int'(mins_bcd), 8'h59);
        chk("pre_s", int'(secs_bcd), 8'h59);
        inc_min = 1'b1;
        step();
        inc_min = 1'b0;
        chk("coll_h", int'(hours_bcd), 8'h11);
        chk("coll_m", int'(mins_bcd), 8'h00);
        chk("coll_s", int'(secs_bcd), 8'h00);
        step();
        chk("pend_m", int'(mins_bcd), 8'h01);
        chk("pend_h", int'(hours_bcd), 8'h11);

        // Hold mode.
        set_hold = 1'b1;
        step();
        chk("hold_s", int'(secs_bcd), 0);
        repeat (3) pulse_hour();
        chk("hold_h", int'(hours_bcd), 8'h14);
        repeat (6) step();
        set_hold = 1'b0;
        n = 0;
        do begin step(); n++; end while (!sec_tick && n < 20);
        chk("release_lat", n, DIV);

`ifdef BCD_TIMEKEEPER_ALARM_EN
        alarm_arm = 1'b1;
        set_hold = 1'b1;
        step();
        n = 0;
        while (m_h != 6 && n < 30) begin pulse_hour(); n++; end
        n = 0;
        while (m_m != 29 && n < 70) begin pulse_min(); n++; end
        set_hold = 1'b0;
        run_until_tick("alarm_run", 0);
        chk("alarm_set", int'(alarm_flag), 1);
        chk("alarm_m", int'(mins_bcd), 8'h30);
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        chk("alarm_ack", int'(alarm_flag), 0);
        set_hold = 1'b1;
        step();
        n = 0;
        while (m_m != 29 && n < 70) begin pulse_min(); n++; end
        pulse_min();
        chk("btn_m", int'(mins_bcd), 8'h30);
        chk("btn_noalarm", int'(alarm_flag), 0);
        set_hold = 1'b0;
`endif

        for (int i = 0; i < 3000; i++) begin
            inc_min  = ($urandom_range(7) == 0);
            inc_hour = ($urandom_range(7) == 0);
            if ($urandom_range(49) == 0) mode_12h = ~mode_12h;
            if ($urandom_range(199) == 0) set_hold = ~set_hold;
            Reset = ($urandom_range(499) == 0);
`ifdef BCD_TIMEKEEPER_ALARM_EN
            alarm_arm = ($urandom_range(19) != 0);
            alarm_ack = ($urandom_range(99) == 0);
            alarm_hh  = 8'(to_bcd(m_h));
            alarm_mm  = 8'(to_bcd((m_m + 1) % 60));
`endif
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
